ikari_front_scroll_gen: RTL

- Downstream consumer of the video scroll/flip registers: BSET (INV), MSET (F1X8/F1Y8/F2X8/F2Y8), F1SY, F2SY, plus X-scroll LSB registers.
- Shadows the live register values once per frame, then generates per-pixel scrolled X/Y positions for the two front (tile) layers.
- Outputs are tile map row/column plus fine offsets, which feed the front-layer tile map RAM address and the tile ROM address logic.
- Handles screen flip by counting down instead of up.

---
 rtl/ikari_video_pkg.sv | 27 ++
 rtl/ikari_front_scroll_gen_if.sv | 45 ++++
 rtl/ikari_scroll_axis.sv | 34 +++
 rtl/ikari_front_scroll_gen.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ikari_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ikari_video_pkg
// Brief    : Shared scroll types, widths and blanking edge-detect helper.
// Revision : 1.0
// ============================================================================
package ikari_video_pkg;

   localparam int POS_W = 9;
   localparam int MAP_W = 10;

   typedef logic [POS_W-1:0] scroll_t;

   typedef struct packed {
      logic rise;
      logic fall;
   } edge_t;

   function automatic edge_t edge_detect(input logic i_cur, input logic i_prev);
      edge_t w_e;
      w_e.rise = i_cur & ~i_prev;
      w_e.fall = ~i_cur & i_prev;
      return w_e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ikari_front_scroll_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : ikari_front_scroll_gen_if
// Brief    : Video timing, scroll register and scrolled position bundle.
// Revision : 1.0
// ============================================================================
interface ikari_front_scroll_gen_if;
   import ikari_video_pkg::*;

   logic             pix_ce;
   logic             hblank;
   logic             vblank;
   logic             INV;
   logic [7:0]       F1X;
   logic             F1X8;
   logic [7:0]       F1Y;
   logic             F1Y8;
   logic [7:0]       F2X;
   logic             F2X8;
   logic [7:0]       F2Y;
   logic             F2Y8;
   scroll_t          F1_XPOS;
   scroll_t          F1_YPOS;
   scroll_t          F2_XPOS;
   scroll_t          F2_YPOS;
   logic [MAP_W-1:0] F1_MAP_ADDR;
   logic [MAP_W-1:0] F2_MAP_ADDR;
   logic             PIX_VALID;

   modport master (
      output pix_ce, hblank, vblank, INV,
      output F1X, F1X8, F1Y, F1Y8, F2X, F2X8, F2Y, F2Y8,
      input  F1_XPOS, F1_YPOS, F2_XPOS, F2_YPOS,
      input  F1_MAP_ADDR, F2_MAP_ADDR, PIX_VALID
   );

   modport slave (
      input  pix_ce, hblank, vblank, INV,
      input  F1X, F1X8, F1Y, F1Y8, F2X, F2X8, F2Y, F2Y8,
      output F1_XPOS, F1_YPOS, F2_XPOS, F2_YPOS,
      output F1_MAP_ADDR, F2_MAP_ADDR, PIX_VALID
   );

endinterface
`default_nettype wire

// File: rtl/ikari_scroll_axis.sv
`default_nettype none
// ============================================================================
// Module   : ikari_scroll_axis
// Brief    : 9-bit scroll accumulator; load beats step, steps wrap mod 512.
// Revision : 1.0
// ============================================================================
module ikari_scroll_axis
   import ikari_video_pkg::*;
(
   input  wire logic    clk,
   input  wire logic    rst,
   input  wire logic    i_load,
   input  wire scroll_t i_load_val,
   input  wire logic    i_step,
   input  wire logic    i_down,
   output scroll_t      o_val
);

   scroll_t r_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
      end else if (i_load) begin
         r_acc <= i_load_val;
      end else if (i_step) begin
         r_acc <= i_down ? r_acc - scroll_t'(1) : r_acc + scroll_t'(1);
      end
   end

   assign o_val = r_acc;

endmodule
`default_nettype wire

// File: rtl/ikari_front_scroll_gen.sv
`default_nettype none
// ============================================================================
// Module   : ikari_front_scroll_gen
// Brief    : Per-frame scroll shadowing and per-pixel X/Y for two tile layers.
// Revision : 1.0
// ============================================================================
module ikari_front_scroll_gen
   import ikari_video_pkg::*;
#(
   parameter int      HVIS      = 256,
   parameter int      VVIS      = 224,
   parameter scroll_t HOFS      = 9'd0,
   parameter scroll_t VOFS      = 9'd0,
   parameter int      TILE_BITS = 4
)(
   input  wire logic               clk,
   input  wire logic               reset,
   ikari_front_scroll_gen_if.slave bus
);

   localparam scroll_t c_XFLIP = scroll_t'(HVIS - 1);
   localparam scroll_t c_YFLIP = scroll_t'(VVIS - 1);
   localparam int      c_NLAY  = 2;

   logic    r_vblank_d;
   logic    r_hblank_d;
   logic    r_sinv;
   scroll_t r_sx [c_NLAY];
   scroll_t r_sy [c_NLAY];
   logic    r_seen_rise;
   logic    r_armed;
   scroll_t r_xpos [c_NLAY];
   scroll_t r_ypos [c_NLAY];
   logic    r_pix_valid;

   edge_t   w_vb;
   edge_t   w_hb;
   scroll_t w_live_x [c_NLAY];
   scroll_t w_live_y [c_NLAY];
   scroll_t w_xacc   [c_NLAY];
   scroll_t w_yacc   [c_NLAY];
   logic    w_xstep;
   logic    w_ystep;

   assign w_vb    = edge_detect(bus.vblank, r_vblank_d);
   assign w_hb    = edge_detect(bus.hblank, r_hblank_d);
   assign w_xstep = bus.pix_ce & ~bus.hblank;
   assign w_ystep = w_hb.rise & ~bus.vblank;

   assign w_live_x[0] = {bus.F1X8, bus.F1X};
   assign w_live_y[0] = {bus.F1Y8, bus.F1Y};
   assign w_live_x[1] = {bus.F2X8, bus.F2X};
   assign w_live_y[1] = {bus.F2Y8, bus.F2Y};

   // Outputs stay blank after reset until one full vblank has been seen, so
   // stale zero shadows are never presented as a real picture.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vblank_d  <= 1'b0;
         r_hblank_d  <= 1'b0;
         r_sinv      <= 1'b0;
         r_seen_rise <= 1'b0;
         r_armed     <= 1'b0;
         r_pix_valid <= 1'b0;
         for (int i = 0; i < c_NLAY; i++) begin
            r_sx[i]   <= '0;
            r_sy[i]   <= '0;
            r_xpos[i] <= '0;
            r_ypos[i] <= '0;
         end
      end else begin
         r_vblank_d <= bus.vblank;
         r_hblank_d <= bus.hblank;
         if (w_vb.rise) begin
            r_sinv      <= bus.INV;
            r_seen_rise <= 1'b1;
            for (int i = 0; i < c_NLAY; i++) begin
               r_sx[i] <= w_live_x[i];
               r_sy[i] <= w_live_y[i];
            end
         end
         if (w_vb.fall && r_seen_rise) begin
            r_armed <= 1'b1;
         end
         if (bus.pix_ce && r_armed) begin
            r_pix_valid <= ~bus.hblank & ~bus.vblank;
            for (int i = 0; i < c_NLAY; i++) begin
               r_xpos[i] <= w_xacc[i];
               r_ypos[i] <= w_yacc[i];
            end
         end
      end
   end

   for (genvar gi = 0; gi < c_NLAY; gi++) begin : g_layer
      scroll_t w_xload;
      scroll_t w_yload;

      // Flipped screens start at the far edge and count back toward zero.
      assign w_xload = r_sx[gi] + HOFS + (r_sinv ? c_XFLIP : scroll_t'(0));
      assign w_yload = r_sy[gi] + VOFS + (r_sinv ? c_YFLIP : scroll_t'(0));

      ikari_scroll_axis u_xaxis (
         .clk        (clk),
         .rst        (reset),
         .i_load     (w_hb.fall),
         .i_load_val (w_xload),
         .i_step     (w_xstep),
         .i_down     (r_sinv),
         .o_val      (w_xacc[gi])
      );

      ikari_scroll_axis u_yaxis (
         .clk        (clk),
         .rst        (reset),
         .i_load     (w_vb.fall),
         .i_load_val (w_yload),
         .i_step     (w_ystep),
         .i_down     (r_sinv),
         .o_val      (w_yacc[gi])
      );
   end

   assign bus.F1_XPOS     = r_xpos[0];
   assign bus.F1_YPOS     = r_ypos[0];
   assign bus.F2_XPOS     = r_xpos[1];
   assign bus.F2_YPOS     = r_ypos[1];
   assign bus.PIX_VALID   = r_pix_valid;
   assign bus.F1_MAP_ADDR = MAP_W'({r_ypos[0][POS_W-1:TILE_BITS], r_xpos[0][POS_W-1:TILE_BITS]});
   assign bus.F2_MAP_ADDR = MAP_W'({r_ypos[1][POS_W-1:TILE_BITS], r_xpos[1][POS_W-1:TILE_BITS]});

endmodule
`default_nettype wire
